// File: rtl/bank_link_master_pkg.sv
// -----------------------------------------------------------------------------
// bank_link_master_pkg
// Shared constants and sizing helpers for the bank-link host initiator.
//   CMD_WR_BIT / CMD_BURST_BIT : flag positions inside the command byte
//   MAX_ADDR_W                 : widest bank address the command byte can carry
//   fun_sizeof_byte            : number of bytes needed to hold a bit width
//   fun_limit                  : clamp a value into [lo, hi]
// -----------------------------------------------------------------------------
package bank_link_master_pkg;

    localparam int CMD_WR_BIT    = 7;
    localparam int CMD_BURST_BIT = 6;
    localparam int MAX_ADDR_W    = 6;

    function automatic int fun_sizeof_byte(input int bits);
        return (bits + 7) / 8;
    endfunction

    function automatic int fun_limit(input int lo, input int val, input int hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

endpackage

// File: rtl/bank_link_master_if.sv
// -----------------------------------------------------------------------------
// bank_link_master_if
// Bundles the request, write-data, read-data, status and UART FIFO signals of
// the bank-link initiator.
//   master : view of the initiator itself
//   slave  : view of the local controller plus the UART TX/RX FIFO pair
// -----------------------------------------------------------------------------
interface bank_link_master_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  i_req_valid;
    logic                  o_req_rdy;
    logic                  i_req_wr;
    logic                  i_req_burst;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  i_wdata_valid;
    logic                  o_wdata_rd;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_rdata_valid;
    logic                  o_done;
    logic                  o_err;
    logic [7:0]            o_tx_data;
    logic                  o_tx_wr;
    logic                  i_tx_rdy;
    logic [7:0]            i_rx_data;
    logic                  i_rx_valid;
    logic                  o_rx_rd;

    modport master (
        input  i_req_valid, i_req_wr, i_req_burst, i_req_addr,
        input  i_wdata, i_wdata_valid, i_tx_rdy, i_rx_data, i_rx_valid,
        output o_req_rdy, o_wdata_rd, o_rdata, o_rdata_valid, o_done, o_err,
        output o_tx_data, o_tx_wr, o_rx_rd
    );

    modport slave (
        output i_req_valid, i_req_wr, i_req_burst, i_req_addr,
        output i_wdata, i_wdata_valid, i_tx_rdy, i_rx_data, i_rx_valid,
        input  o_req_rdy, o_wdata_rd, o_rdata, o_rdata_valid, o_done, o_err,
        input  o_tx_data, o_tx_wr, o_rx_rd
    );
endinterface

// File: rtl/bank_link_shifter.sv
// -----------------------------------------------------------------------------
// bank_link_shifter
// NB-byte shift register shared by the TX and RX directions, MSB byte first.
//   load/load_data : parallel load, byte counter set to NB-1
//   shift_out      : shift left one byte (top_byte is the byte being sent)
//   shift_in       : shift left one byte, in_byte enters at the bottom
//   rearm          : set byte counter to NB-1 without touching the data
//   data/top_byte  : register contents / current most significant byte
//   last           : byte counter is zero (current byte is the final one)
// -----------------------------------------------------------------------------
module bank_link_shifter #(
    parameter int NB = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [NB*8-1:0] load_data,
    input  logic            shift_out,
    input  logic            shift_in,
    input  logic [7:0]      in_byte,
    input  logic            rearm,
    output logic [NB*8-1:0] data,
    output logic [7:0]      top_byte,
    output logic            last
);
    localparam int W  = NB * 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(NB - 1);

    logic [W-1:0]  sreg;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= load_data;
            cnt  <= CNT_INIT;
        end else begin
            if (shift_out)
                sreg <= sreg << 8;
            else if (shift_in)
                sreg <= (sreg << 8) | W'(in_byte);
            // rearm wins over the decrement so a command-byte push can
            // prepare the counter for the first returned word
            if (rearm)
                cnt <= CNT_INIT;
            else if ((shift_out || shift_in) && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    assign data     = sreg;
    assign top_byte = sreg[W-1 -: 8];
    assign last     = (cnt == '0);

endmodule

// File: rtl/bank_link_master.sv
// -----------------------------------------------------------------------------
// bank_link_master
// Host-side initiator of the byte-oriented bank-access protocol. Turns a
// word-level read/write request into a command byte plus data bytes toward a
// UART TX FIFO and reassembles returned RX bytes into words.
//   i_clk, i_arst : clock, asynchronous active-high reset
//   bus (master)  : request, write data, read data, done/err and UART FIFO
//                   signals (see bank_link_master_if)
// -----------------------------------------------------------------------------
module bank_link_master
    import bank_link_master_pkg::*;
#(
    parameter int BANK_DATA_WIDTH  = 16,
    parameter int BANK_ADDR_WIDTH  = 3,
    parameter int RX_TIMEOUT_WIDTH = 8
) (
    input  logic i_clk,
    input  logic i_arst,
    bank_link_master_if.master bus
);
    localparam int NB = fun_sizeof_byte(BANK_DATA_WIDTH);
    localparam int AW = fun_limit(1, BANK_ADDR_WIDTH, MAX_ADDR_W);
    localparam int SW = NB * 8;

    localparam logic [AW:0] WC_ONE  = (AW+1)'(1);
    localparam logic [AW:0] WC_FULL = WC_ONE << AW;
    localparam logic [RX_TIMEOUT_WIDTH-1:0] TMO_ALL  = '1;
    localparam logic [RX_TIMEOUT_WIDTH-1:0] TMO_LAST = TMO_ALL - 1'b1;

    typedef enum logic [9:0] {
        S_IDLE     = 10'b00_0000_0001,
        S_TX_WAIT  = 10'b00_0000_0010,
        S_TX_PUSH  = 10'b00_0000_0100,
        S_WD_WAIT  = 10'b00_0000_1000,
        S_RX_WAIT  = 10'b00_0001_0000,
        S_RX_POP   = 10'b00_0010_0000,
        S_RDATA    = 10'b00_0100_0000,
        S_WORD_END = 10'b00_1000_0000,
        S_DONE     = 10'b01_0000_0000,
        S_ERR      = 10'b10_0000_0000
    } state_t;

    state_t state_q, state_d;

    logic                        wr_q;
    logic                        cmd_phase_q;  // shift register holds the command byte
    logic [AW:0]                 wc_q;
    logic [RX_TIMEOUT_WIDTH-1:0] tmo_q;
    logic [BANK_DATA_WIDTH-1:0]  rdata_q;

    logic          sh_load, sh_shift_out, sh_shift_in, sh_rearm, sh_last;
    logic [SW-1:0] sh_load_data, sh_data;
    logic [7:0]    sh_top;
    logic [7:0]    cmd_byte;
    logic [AW:0]   wc_init;

    bank_link_shifter #(.NB(NB)) u_shifter (
        .clk       (i_clk),
        .rst       (i_arst),
        .load      (sh_load),
        .load_data (sh_load_data),
        .shift_out (sh_shift_out),
        .shift_in  (sh_shift_in),
        .in_byte   (bus.i_rx_data),
        .rearm     (sh_rearm),
        .data      (sh_data),
        .top_byte  (sh_top),
        .last      (sh_last)
    );

    always_comb begin
        cmd_byte                = 8'(bus.i_req_addr);
        cmd_byte[CMD_WR_BIT]    = bus.i_req_wr;
        cmd_byte[CMD_BURST_BIT] = bus.i_req_burst;
    end

    // a burst runs to the top of the bank, never wrapping
    assign wc_init = bus.i_req_burst ? (WC_FULL - {1'b0, bus.i_req_addr}) : WC_ONE;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wr_q        <= 1'b0;
            cmd_phase_q <= 1'b0;
            wc_q        <= '0;
            tmo_q       <= '0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tmo_q <= '0;
                    if (bus.i_req_valid) begin
                        wr_q        <= bus.i_req_wr;
                        cmd_phase_q <= 1'b1;
                        wc_q        <= wc_init;
                    end
                end
                S_TX_PUSH:  cmd_phase_q <= 1'b0;
                S_RX_WAIT:  if (!bus.i_rx_valid) tmo_q <= tmo_q + 1'b1;
                S_RX_POP:   tmo_q <= '0;
                S_RDATA:    rdata_q <= sh_data[BANK_DATA_WIDTH-1:0];
                S_WORD_END: wc_q <= wc_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d           = state_q;
        sh_load           = 1'b0;
        sh_load_data      = '0;
        sh_shift_out      = 1'b0;
        sh_shift_in       = 1'b0;
        sh_rearm          = 1'b0;
        bus.o_req_rdy     = 1'b0;
        bus.o_wdata_rd    = 1'b0;
        bus.o_rdata_valid = 1'b0;
        bus.o_done        = 1'b0;
        bus.o_err         = 1'b0;
        bus.o_tx_wr       = 1'b0;
        bus.o_rx_rd       = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.o_req_rdy = 1'b1;
                if (bus.i_req_valid) begin
                    sh_load      = 1'b1;
                    sh_load_data = SW'(cmd_byte) << (SW - 8);
                    state_d      = S_TX_WAIT;
                end
            end
            S_TX_WAIT: if (bus.i_tx_rdy) state_d = S_TX_PUSH;
            S_TX_PUSH: begin
                bus.o_tx_wr  = 1'b1;
                sh_shift_out = 1'b1;
                if (cmd_phase_q) begin
                    if (wr_q) begin
                        state_d = S_WD_WAIT;
                    end else begin
                        sh_rearm = 1'b1;
                        state_d  = S_RX_WAIT;
                    end
                end else if (!sh_last) begin
                    state_d = S_TX_WAIT;
                end else begin
                    state_d = S_WORD_END;
                end
            end
            S_WD_WAIT: begin
                if (bus.i_wdata_valid) begin
                    bus.o_wdata_rd = 1'b1;
                    sh_load        = 1'b1;
                    sh_load_data   = SW'(bus.i_wdata);
                    state_d        = S_TX_WAIT;
                end
            end
            S_RX_WAIT: begin
                if (bus.i_rx_valid)        state_d = S_RX_POP;
                else if (tmo_q == TMO_LAST) state_d = S_ERR;
            end
            S_RX_POP: begin
                bus.o_rx_rd = 1'b1;
                sh_shift_in = 1'b1;
                state_d     = sh_last ? S_RDATA : S_RX_WAIT;
            end
            S_RDATA: begin
                bus.o_rdata_valid = 1'b1;
                state_d           = S_WORD_END;
            end
            S_WORD_END: begin
                if (wc_q == WC_ONE) begin
                    state_d = S_DONE;
                end else if (wr_q) begin
                    state_d = S_WD_WAIT;
                end else begin
                    sh_rearm = 1'b1;
                    state_d  = S_RX_WAIT;
                end
            end
            S_DONE: begin
                bus.o_done = 1'b1;
                state_d    = S_IDLE;
            end
            S_ERR: begin
                // stale RX bytes stay in the FIFO for the owner to drain
                bus.o_err = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // the freshly assembled word is visible during its valid pulse, then held
    assign bus.o_rdata   = (state_q == S_RDATA) ? sh_data[BANK_DATA_WIDTH-1:0] : rdata_q;
    assign bus.o_tx_data = sh_top;

endmodule

// File: doc/bank_link_master.md
Name: bank_link_master

Overview:
- Host-side initiator for the byte-oriented bank-access protocol that the on-chip PC interface handler answers.
- Converts word-level read/write requests into the command byte plus data-byte stream, and reassembles returned bytes into words.
- Sits between a local controller (bridge FPGA/MCU port or system testbench driver) and a UART TX/RX FIFO pair.

Parameters:
- BANK_DATA_WIDTH, 16, bank word width; bytes per word NB = ceil(BANK_DATA_WIDTH/8).
- BANK_ADDR_WIDTH, 3, bank address width; effective AW = limit(1, BANK_ADDR_WIDTH, 6).
- RX_TIMEOUT_WIDTH, 8, width of the read idle-timeout counter; timeout = 2^RX_TIMEOUT_WIDTH-1 cycles.

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  asynchronous reset, active-high.
- i_req_valid  in  1  request strobe, accepted when o_req_rdy=1.
- o_req_rdy  out  1  high only in S_IDLE.
- i_req_wr  in  1  1=write, 0=read.
- i_req_burst  in  1  1=auto-increment burst to address 2^AW-1.
- i_req_addr  in  AW  start address.
- i_wdata  in  BANK_DATA_WIDTH  write word.
- i_wdata_valid  in  1  write word available.
- o_wdata_rd  out  1  1-cycle pop of the write word.
- o_rdata  out  BANK_DATA_WIDTH  assembled read word.
- o_rdata_valid  out  1  1-cycle pulse per read word.
- o_done  out  1  1-cycle pulse at end of transfer.
- o_err  out  1  1-cycle pulse on read timeout.
- o_tx_data  out  8  byte to UART TX FIFO.
- o_tx_wr  out  1  1-cycle push.
- i_tx_rdy  in  1  TX FIFO not full.
- i_rx_data  in  8  first-word-fall-through RX byte.
- i_rx_valid  in  1  RX FIFO not empty.
- o_rx_rd  out  1  1-cycle pop.

Behaviour:
- Reset: all outputs 0 except o_req_rdy=1 (S_IDLE); shift registers, counters and timeout cleared. Reset mid-transfer aborts immediately without o_done or o_err; partial stream is not completed.
- Command byte = {wr, burst, 0-pad, addr[AW-1:0]}, addr in bits [AW-1:0].
- Word count WC = burst ? 2^AW - addr : 1. Computed at accept in an AW+1-bit counter; no wrap past 2^AW-1.
- Byte order is MSB byte first. Shift register width is NB*8.
  - Write: word zero-extended to NB*8.
  - Read: o_rdata = low BANK_DATA_WIDTH bits of the shifted-in bytes.
- States (one-hot, Moore outputs):
  - S_IDLE: accept request; latch wr, burst, addr; load WC; cmd byte to shift_out → S_TX_WAIT.
  - S_TX_WAIT: wait for i_tx_rdy → S_TX_PUSH.
  - S_TX_PUSH: o_tx_wr=1, o_tx_data = shift_out top byte; shift left 8. Next state:
    - Command byte sent: write → S_WD_WAIT, read → S_RX_WAIT.
    - Write data byte with bytes remaining → S_TX_WAIT.
    - Last byte of word → S_WORD_END.
  - S_WD_WAIT: on i_wdata_valid, o_wdata_rd=1 that cycle, load word, byte_cnt=NB-1 → S_TX_WAIT.
  - S_RX_WAIT: timeout counter increments each cycle.
    - On i_rx_valid → S_RX_POP.
    - If the counter reaches all-ones first → S_ERR.
  - S_RX_POP: o_rx_rd=1; shift in i_rx_data; clear timeout.
    - Bytes remaining → S_RX_WAIT.
    - Last byte → S_RDATA.
  - S_RDATA: o_rdata_valid=1 → S_WORD_END.
  - S_WORD_END: decrement WC. WC reaches 0 → S_DONE; else write → S_WD_WAIT, read → S_RX_WAIT with byte_cnt=NB-1.
  - S_DONE: o_done=1 → S_IDLE.
  - S_ERR: o_err=1 → S_IDLE. Stale RX bytes are not flushed; the owner drains the FIFO.
- Minimum 2 cycles per TX byte and 2 per RX byte. i_req_valid outside S_IDLE is ignored. i_tx_rdy is sampled only in S_TX_WAIT; i_rx_valid only in S_RX_WAIT.
- o_rdata holds its value until the next read word.

Decomposition:
- Shared header constants:
  - Command bit positions (CMD_WR_BIT=7, CMD_BURST_BIT=6).
  - Max address width 6.
  - Existing fun_sizeof_byte / fun_limit macros.
- State encodings stay local.
- One natural sub-module, bank_link_shifter: NB-byte load/shift-in/shift-out register with byte counter and last flag. Used for both directions.

Test Plan:
- Single write, addr 5, word 0xABCD (16b/3b) → tx 0x85,0xAB,0xCD; one o_wdata_rd; one o_done; no o_rx_rd.
- Single read, addr 2, rx 0x12,0x34 → tx 0x02; o_rdata_valid once with 0x1234; then o_done.
- Burst write, addr 6, words 0x1111,0x2222 → tx 0xC6,0x11,0x11,0x22,0x22; exactly 2 o_wdata_rd; o_done after 5th push.
- Burst read, addr 0, 16 rx bytes → tx 0x40; 8 o_rdata_valid pulses in order; i_tx_rdy low for 10 cycles mid-burst write → no o_tx_wr while low, byte order intact.
- BANK_DATA_WIDTH=12: write 0xABC → 0x0A,0xBC; read 0x0A,0xBC → 0xABC.
- RX_TIMEOUT_WIDTH=4, read, no rx → o_err after 15 cycles, o_done never; reset asserted mid-burst → o_req_rdy=1 next cycle, all strobes 0.
